// File: rtl/tiny_arb_pkg.sv
// Shared types and default constants for the tiny two-requester memory arbiter.
package tiny_arb_pkg;

   localparam logic [31:0] DefBaseAddr = 32'h3000_0000;
   localparam int unsigned DefAddrW    = 3;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StAck
   } arb_state_e;

   typedef enum logic {
      ReqWb = 1'b0,
      ReqLa = 1'b1
   } req_id_e;

endpackage

// File: rtl/tiny_rr_arb2.sv
// Two-way round-robin picker: on contention grants the requester not served last.
module tiny_rr_arb2
   import tiny_arb_pkg::*;
(
   input  logic wb_valid_i,
   input  logic la_valid_i,
   input  logic last_i,
   output logic gnt_o
);

   always_comb begin
      gnt_o = ReqWb;
      if (wb_valid_i && la_valid_i) begin
         gnt_o = (last_i == ReqWb) ? ReqLa : ReqWb;
      end else if (la_valid_i) begin
         gnt_o = ReqLa;
      end
   end

endmodule

// File: rtl/tiny_mem_arbiter.sv
// Arbitrates a Wishbone slave port and a logic-analyser port onto one single-port memory.
// Optional contention interrupt counter is built when TINY_ARB_IRQ_EN is defined.
module tiny_mem_arbiter
   import tiny_arb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DefBaseAddr,
   parameter int unsigned ADDR_W    = DefAddrW
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic              la_req_i,
   input  logic              la_we_i,
   input  logic [ADDR_W-1:0] la_adr_i,
   input  logic [31:0]       la_dat_i,
   output logic              la_ack_o,
   output logic [31:0]       la_dat_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_sel_o,
   output logic [ADDR_W-1:0] mem_adr_o,
   output logic [31:0]       mem_wdat_o,
   input  logic [31:0]       mem_rdat_i,
   input  logic              irq_clr_i,
   output logic              irq_o
);

   arb_state_e        state_q, state_d;
   req_id_e           gnt_q, gnt_d, last_q, last_d;
   logic              we_q, we_d, miss_q, miss_d;
   logic [3:0]        sel_q, sel_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [31:0]       wdat_q, wdat_d;
   logic [31:0]       ack_dat;
   logic              wb_req, wb_hit, contended, pick;

   assign wb_req    = wbs_cyc_i & wbs_stb_i;
   assign wb_hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign contended = wb_req & la_req_i;

   logic unused_adr;
   assign unused_adr = ^{wbs_adr_i[7:ADDR_W+2], wbs_adr_i[1:0]};

   tiny_rr_arb2 u_rr (
      .wb_valid_i (wb_req),
      .la_valid_i (la_req_i),
      .last_i     (last_q),
      .gnt_o      (pick)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= StIdle;
         gnt_q   <= ReqWb;
         last_q  <= ReqLa;
         we_q    <= 1'b0;
         miss_q  <= 1'b0;
         sel_q   <= 4'h0;
         adr_q   <= '0;
         wdat_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         we_q    <= we_d;
         miss_q  <= miss_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      we_d       = we_q;
      miss_d     = miss_q;
      sel_d      = sel_q;
      adr_d      = adr_q;
      wdat_d     = wdat_q;
      ack_dat    = 32'h0;
      wbs_ack_o  = 1'b0;
      wbs_dat_o  = 32'h0;
      la_ack_o   = 1'b0;
      la_dat_o   = 32'h0;
      mem_en_o   = 1'b0;
      mem_we_o   = 1'b0;
      mem_sel_o  = 4'h0;
      mem_adr_o  = '0;
      mem_wdat_o = 32'h0;
      case (state_q)
         StIdle: begin
            if (wb_req || la_req_i) begin
               state_d = StAccess;
               gnt_d   = req_id_e'(pick);
               if (req_id_e'(pick) == ReqWb) begin
                  we_d   = wbs_we_i;
                  sel_d  = wbs_sel_i;
                  adr_d  = wbs_adr_i[ADDR_W+1:2];
                  wdat_d = wbs_dat_i;
                  miss_d = ~wb_hit;
               end else begin
                  we_d   = la_we_i;
                  sel_d  = 4'hF;
                  adr_d  = la_adr_i;
                  wdat_d = la_dat_i;
                  miss_d = 1'b0;
               end
            end
         end
         StAccess: begin
            state_d = StAck;
            // Out-of-window WB cycles never touch memory; they are only acked.
            if (!miss_q) begin
               mem_en_o   = 1'b1;
               mem_we_o   = we_q;
               mem_sel_o  = sel_q;
               mem_adr_o  = adr_q;
               mem_wdat_o = wdat_q;
            end
         end
         StAck: begin
            state_d = StIdle;
            last_d  = gnt_q;
            ack_dat = (we_q || miss_q) ? 32'h0 : mem_rdat_i;
            if (gnt_q == ReqWb) begin
               wbs_ack_o = 1'b1;
               wbs_dat_o = ack_dat;
            end else begin
               la_ack_o = 1'b1;
               la_dat_o = ack_dat;
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef TINY_ARB_IRQ_EN
   logic [7:0] cont_cnt_q;
   logic       cont_grant;

   assign cont_grant = (state_q == StIdle) & contended;

   // Clear has priority; the count saturates at 8'hFF.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         cont_cnt_q <= 8'h00;
      end else if (irq_clr_i) begin
         cont_cnt_q <= 8'h00;
      end else if (cont_grant && (cont_cnt_q != 8'hFF)) begin
         cont_cnt_q <= cont_cnt_q + 8'h01;
      end
   end

   assign irq_o = (cont_cnt_q == 8'hFF);
`else
   logic unused_irq;
   assign unused_irq = irq_clr_i ^ contended;
   assign irq_o      = 1'b0;
`endif

endmodule
